// File: rtl/riscv_memalign.sv
`default_nettype none
// ============================================================================
// Module   : riscv_memalign
// Purpose  : Load aligner that splits misaligned loads into one or two aligned
//            memory beats and returns the sign/zero-extended result.
// Revision : 1.0
// ============================================================================
module riscv_memalign #(
    parameter int XLEN        = 64,
    parameter int MISALIGN_EN = 1
) (
    input  logic            i_riscv_memalign_clk,
    input  logic            i_riscv_memalign_rst,
    input  logic            i_riscv_memalign_req_valid,
    output logic            o_riscv_memalign_req_ready,
    input  logic [2:0]      i_riscv_memalign_sel,
    input  logic [XLEN-1:0] i_riscv_memalign_addr,
    output logic            o_riscv_memalign_mem_req,
    output logic [XLEN-1:0] o_riscv_memalign_mem_addr,
    input  logic            i_riscv_memalign_mem_rvalid,
    input  logic [XLEN-1:0] i_riscv_memalign_mem_rdata,
    output logic            o_riscv_memalign_resp_valid,
    input  logic            i_riscv_memalign_resp_ready,
    output logic [XLEN-1:0] o_riscv_memalign_resp_data,
    output logic            o_riscv_memalign_resp_fault
);

    localparam int              BYTES   = XLEN / 8;
    localparam int              OFFW    = $clog2(BYTES);
    localparam logic [OFFW+1:0] c_bytes = BYTES[OFFW+1:0];
    localparam logic [XLEN-1:0] c_step  = XLEN'(BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_sel;
    logic [XLEN-1:0]   r_base;
    logic [OFFW-1:0]   r_off;
    logic [XLEN-1:0]   r_beat0;
    logic [XLEN-1:0]   r_data;
    logic              r_fault;

    logic [2:0]        w_amask;
    logic              w_illegal;
    logic [OFFW+1:0]   w_nbytes;
    logic              w_cross;
    logic [2*XLEN-1:0] w_src;
    logic [OFFW:0]     w_idx;
    logic [XLEN-1:0]   w_shift;
    logic [63:0]       w_mask64;
    logic [XLEN-1:0]   w_mask;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    always_comb begin
        w_amask = 3'b000;
        case (i_riscv_memalign_sel[1:0])
            2'd0:    w_amask = 3'b000;
            2'd1:    w_amask = 3'b001;
            2'd2:    w_amask = 3'b011;
            default: w_amask = 3'b111;
        endcase
        w_illegal = (i_riscv_memalign_sel == 3'b111)
                 || ((i_riscv_memalign_sel[1:0] == 2'd3) && (XLEN == 32))
                 || ((MISALIGN_EN == 0) && ((i_riscv_memalign_addr[2:0] & w_amask) != 3'b000));
    end

    assign w_nbytes = (OFFW+2)'(1) << r_sel[1:0];
    assign w_cross  = (({2'b00, r_off} + w_nbytes) > c_bytes);

    // Second beat is zero while the first beat is still on the bus.
    assign w_src = (r_state == RD1) ? {i_riscv_memalign_mem_rdata, r_beat0}
                                    : {{XLEN{1'b0}}, i_riscv_memalign_mem_rdata};

    always_comb begin
        w_shift = '0;
        w_idx   = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_idx = {1'b0, r_off} + (OFFW+1)'(i);
            w_shift[i*8 +: 8] = w_src[{w_idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        w_mask64 = '1;
        w_sign   = w_shift[XLEN-1];
        case (r_sel[1:0])
            2'd0: begin w_mask64 = 64'h0000_0000_0000_00FF; w_sign = w_shift[7];  end
            2'd1: begin w_mask64 = 64'h0000_0000_0000_FFFF; w_sign = w_shift[15]; end
            2'd2: begin w_mask64 = 64'h0000_0000_FFFF_FFFF; w_sign = w_shift[31]; end
            default: ;
        endcase
        w_mask = w_mask64[XLEN-1:0];
        w_ext  = (w_shift & w_mask) | ((w_sign && !r_sel[2]) ? ~w_mask : '0);
    end

    always_ff @(posedge i_riscv_memalign_clk or posedge i_riscv_memalign_rst) begin
        if (i_riscv_memalign_rst) r_state <= IDLE;
        else                      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (i_riscv_memalign_req_valid)   w_state_nxt = w_illegal ? RESP : RD0;
            RD0:  if (i_riscv_memalign_mem_rvalid)  w_state_nxt = w_cross ? RD1 : RESP;
            RD1:  if (i_riscv_memalign_mem_rvalid)  w_state_nxt = RESP;
            RESP: if (i_riscv_memalign_resp_ready)  w_state_nxt = IDLE;
            default:                                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_memalign_clk or posedge i_riscv_memalign_rst) begin
        if (i_riscv_memalign_rst) begin
            r_sel   <= '0;
            r_base  <= '0;
            r_off   <= '0;
            r_beat0 <= '0;
            r_data  <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_riscv_memalign_req_valid) begin
                    r_sel   <= i_riscv_memalign_sel;
                    r_base  <= {i_riscv_memalign_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    r_off   <= i_riscv_memalign_addr[OFFW-1:0];
                    r_beat0 <= '0;
                    r_data  <= '0;
                    r_fault <= w_illegal;
                end
                RD0: if (i_riscv_memalign_mem_rvalid) begin
                    r_beat0 <= i_riscv_memalign_mem_rdata;
                    if (!w_cross) r_data <= w_ext;
                end
                RD1: if (i_riscv_memalign_mem_rvalid) r_data <= w_ext;
                RESP: if (i_riscv_memalign_resp_ready) begin
                    r_data  <= '0;
                    r_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_riscv_memalign_req_ready  = (r_state == IDLE);
    assign o_riscv_memalign_mem_req    = (r_state == RD0) || (r_state == RD1);
    assign o_riscv_memalign_mem_addr   = (r_state == RD0) ? r_base
                                       : (r_state == RD1) ? (r_base + c_step)
                                       : '0;
    assign o_riscv_memalign_resp_valid = (r_state == RESP);
    assign o_riscv_memalign_resp_data  = r_data;
    assign o_riscv_memalign_resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_riscv_memalign.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_memalign
// Purpose  : Table-driven scoreboard bench for riscv_memalign (XLEN = 64).
// Revision : 1.0
// ============================================================================
module tb_riscv_memalign;

    localparam logic [63:0] RA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] RB = 64'h7766_5544_3322_1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic [63:0] addr = '0;
    logic        rvalid = 1'b0;
    logic [63:0] rdata = '0;
    logic        use_na = 1'b0;

    logic        a_req_ready, a_mem_req, a_resp_valid, a_resp_fault;
    logic [63:0] a_mem_addr, a_resp_data;
    logic        n_req_ready, n_mem_req, n_resp_valid, n_resp_fault;
    logic [63:0] n_mem_addr, n_resp_data;
    logic        m_req_ready, m_mem_req, m_resp_valid, m_resp_fault;
    logic [63:0] m_mem_addr, m_resp_data;
    logic        req_valid_a, req_valid_n;

    always #5 clk = ~clk;

    assign req_valid_a  = req_valid & ~use_na;
    assign req_valid_n  = req_valid &  use_na;
    assign m_req_ready  = use_na ? n_req_ready  : a_req_ready;
    assign m_mem_req    = use_na ? n_mem_req    : a_mem_req;
    assign m_mem_addr   = use_na ? n_mem_addr   : a_mem_addr;
    assign m_resp_valid = use_na ? n_resp_valid : a_resp_valid;
    assign m_resp_data  = use_na ? n_resp_data  : a_resp_data;
    assign m_resp_fault = use_na ? n_resp_fault : a_resp_fault;

    riscv_memalign #(.XLEN(64), .MISALIGN_EN(1)) dut (
        .i_riscv_memalign_clk        (clk),
        .i_riscv_memalign_rst        (rst),
        .i_riscv_memalign_req_valid  (req_valid_a),
        .o_riscv_memalign_req_ready  (a_req_ready),
        .i_riscv_memalign_sel        (sel),
        .i_riscv_memalign_addr       (addr),
        .o_riscv_memalign_mem_req    (a_mem_req),
        .o_riscv_memalign_mem_addr   (a_mem_addr),
        .i_riscv_memalign_mem_rvalid (rvalid),
        .i_riscv_memalign_mem_rdata  (rdata),
        .o_riscv_memalign_resp_valid (a_resp_valid),
        .i_riscv_memalign_resp_ready (resp_ready),
        .o_riscv_memalign_resp_data  (a_resp_data),
        .o_riscv_memalign_resp_fault (a_resp_fault)
    );

    riscv_memalign #(.XLEN(64), .MISALIGN_EN(0)) dut_na (
        .i_riscv_memalign_clk        (clk),
        .i_riscv_memalign_rst        (rst),
        .i_riscv_memalign_req_valid  (req_valid_n),
        .o_riscv_memalign_req_ready  (n_req_ready),
        .i_riscv_memalign_sel        (sel),
        .i_riscv_memalign_addr       (addr),
        .o_riscv_memalign_mem_req    (n_mem_req),
        .o_riscv_memalign_mem_addr   (n_mem_addr),
        .i_riscv_memalign_mem_rvalid (rvalid),
        .i_riscv_memalign_mem_rdata  (rdata),
        .o_riscv_memalign_resp_valid (n_resp_valid),
        .i_riscv_memalign_resp_ready (resp_ready),
        .o_riscv_memalign_resp_data  (n_resp_data),
        .o_riscv_memalign_resp_fault (n_resp_fault)
    );

    typedef struct {
        logic        na;
        logic [2:0]  sel;
        logic [63:0] addr;
        int          rdelay;
        int          hold;
        logic [63:0] rd0;
        logic [63:0] rd1;
        logic [63:0] exp_data;
        logic        exp_fault;
        int          exp_beats;
        logic [63:0] a0;
        logic [63:0] a1;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] beat_addr[$];
    vec_t        vecs[19];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdelay = 0;
    int          wait_cnt = 0;
    int          beat_n = 0;
    logic [63:0] cur_rd0 = '0;
    logic [63:0] cur_rd1 = '0;
    logic        force_rvalid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers the selected DUT after rdelay idle cycles per beat.
    always @(negedge clk) begin
        if (force_rvalid) begin
            rvalid = 1'b1;
            rdata  = '1;
        end else if (m_mem_req) begin
            if (wait_cnt >= rdelay) begin
                rvalid = 1'b1;
                rdata  = (beat_n == 0) ? cur_rd0 : cur_rd1;
                beat_addr.push_back(m_mem_addr);
                beat_n   = beat_n + 1;
                wait_cnt = 0;
            end else begin
                rvalid   = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            rvalid   = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL sb_unexpected: got response 0x%h with empty scoreboard", m_resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", m_resp_data, e.data);
                chk("resp_fault", {63'b0, m_resp_fault}, {63'b0, e.fault});
            end
        end
        if (m_mem_req && m_resp_valid) begin
            errors = errors + 1;
            $display("FAIL mem_req_resp_overlap: got both high expected exclusive");
        end
    end

    task automatic run(input vec_t v, input int k);
        exp_t e;
        int   acc;
        int   lat;
        @(posedge clk); #1;
        use_na    = v.na;
        rdelay    = v.rdelay;
        cur_rd0   = v.rd0;
        cur_rd1   = v.rd1;
        beat_n    = 0;
        wait_cnt  = 0;
        beat_addr.delete();
        resp_ready = (v.hold == 0);
        chk($sformatf("v%0d req_ready_idle", k), {63'b0, m_req_ready}, 64'd1);
        sel       = v.sel;
        addr      = v.addr;
        req_valid = 1'b1;
        acc       = cyc;
        e.data    = v.exp_data;
        e.fault   = v.exp_fault;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (m_mem_req && !rvalid)
                chk($sformatf("v%0d mem_addr_held", k), m_mem_addr, (beat_n == 0) ? v.a0 : v.a1);
            if (m_resp_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL v%0d timeout: got no resp_valid expected one within 200 cycles", k);
            void'(sb.pop_back());
            return;
        end
        chk($sformatf("v%0d latency", k), 64'(lat), 64'(v.lat));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk); #1;
            chk($sformatf("v%0d hold_valid", k), {63'b0, m_resp_valid}, 64'd1);
            chk($sformatf("v%0d hold_data", k), m_resp_data, v.exp_data);
            chk($sformatf("v%0d hold_req_ready", k), {63'b0, m_req_ready}, 64'd0);
        end
        if (v.hold > 0) begin
            @(posedge clk); #1;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d resp_valid_drop", k), {63'b0, m_resp_valid}, 64'd0);
        chk($sformatf("v%0d beats", k), 64'(beat_addr.size()), 64'(v.exp_beats));
        if (v.exp_beats >= 1 && beat_addr.size() >= 1) chk($sformatf("v%0d addr0", k), beat_addr[0], v.a0);
        if (v.exp_beats >= 2 && beat_addr.size() >= 2) chk($sformatf("v%0d addr1", k), beat_addr[1], v.a1);
        chk($sformatf("v%0d sb_drained", k), 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int waited;
        //         na    sel     addr                    dly hold rd0   rd1  exp_data                fault beats a0                      a1     lat
        vecs[0]  = '{1'b0, 3'b000, 64'h1003,              0, 0, RA, RB, 64'hFFFF_FFFF_FFFF_FF89, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[1]  = '{1'b0, 3'b010, 64'h1006,              0, 0, RA, RB, 64'h0000_0000_1100_0123, 1'b0, 2, 64'h1000,              64'h1008, 3};
        vecs[2]  = '{1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, RA, RB, 64'h3322_1100_0123_4567, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 3};
        vecs[3]  = '{1'b0, 3'b110, 64'h1004,              0, 0, 64'h8000_0001_0000_0000, RB, 64'h0000_0000_8000_0001, 1'b0, 1, 64'h1000, 64'h0, 2};
        vecs[4]  = '{1'b0, 3'b001, 64'h1001,              0, 0, RA, RB, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[5]  = '{1'b0, 3'b101, 64'h1007,              0, 0, RA, RB, 64'h0000_0000_0000_0001, 1'b0, 2, 64'h1000,              64'h1008, 3};
        vecs[6]  = '{1'b0, 3'b011, 64'h1000,              0, 0, RA, RB, RA,                      1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[7]  = '{1'b0, 3'b010, 64'h1000,              0, 0, RA, RB, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[8]  = '{1'b0, 3'b100, 64'h1003,              0, 0, RA, RB, 64'h0000_0000_0000_0089, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[9]  = '{1'b0, 3'b111, 64'h1000,              0, 0, RA, RB, 64'h0,                   1'b1, 0, 64'h0,                 64'h0, 1};
        vecs[10] = '{1'b0, 3'b000, 64'h1007,              0, 0, RA, RB, 64'h0000_0000_0000_0001, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[11] = '{1'b0, 3'b011, 64'h1001,              0, 0, RA, RB, 64'h0001_2345_6789_ABCD, 1'b0, 2, 64'h1000,              64'h1008, 3};
        vecs[12] = '{1'b0, 3'b010, 64'h1006,              2, 3, RA, RB, 64'h0000_0000_1100_0123, 1'b0, 2, 64'h1000,              64'h1008, 7};
        vecs[13] = '{1'b0, 3'b000, 64'h1003,              4, 0, RA, RB, 64'hFFFF_FFFF_FFFF_FF89, 1'b0, 1, 64'h1000,              64'h0, 6};
        vecs[14] = '{1'b1, 3'b001, 64'h1007,              0, 2, RA, RB, 64'h0,                   1'b1, 0, 64'h0,                 64'h0, 1};
        vecs[15] = '{1'b1, 3'b111, 64'h1000,              0, 0, RA, RB, 64'h0,                   1'b1, 0, 64'h0,                 64'h0, 1};
        vecs[16] = '{1'b1, 3'b010, 64'h1004,              0, 0, RA, RB, 64'h0000_0000_0123_4567, 1'b0, 1, 64'h1000,              64'h0, 2};
        vecs[17] = '{1'b1, 3'b011, 64'h1004,              0, 0, RA, RB, 64'h0,                   1'b1, 0, 64'h0,                 64'h0, 1};
        vecs[18] = '{1'b0, 3'b101, 64'h1006,              0, 0, RA, RB, 64'h0000_0000_0000_0123, 1'b0, 1, 64'h1000,              64'h0, 2};

        repeat (3) @(negedge clk);
        chk("rst req_ready",  {63'b0, a_req_ready},  64'd1);
        chk("rst mem_req",    {63'b0, a_mem_req},    64'd0);
        chk("rst mem_addr",   a_mem_addr,            64'd0);
        chk("rst resp_valid", {63'b0, a_resp_valid}, 64'd0);
        chk("rst resp_data",  a_resp_data,           64'd0);
        chk("rst resp_fault", {63'b0, a_resp_fault}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 19; k++) run(vecs[k], k);

        // Reset while waiting for the second beat, then late rvalid must be ignored.
        @(posedge clk); #1;
        use_na = 1'b0; rdelay = 3; cur_rd0 = RA; cur_rd1 = RB;
        beat_n = 0; wait_cnt = 0; beat_addr.delete();
        resp_ready = 1'b1; sel = 3'b010; addr = 64'h1006; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!(beat_n == 1 && a_mem_req && !rvalid) && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("rd1 reached", {63'b0, (beat_n == 1 && a_mem_req)}, 64'd1);
        chk("rd1 mem_addr", a_mem_addr, 64'h1008);
        rst = 1'b1;
        #1;
        chk("mid rst req_ready",  {63'b0, a_req_ready},  64'd1);
        chk("mid rst mem_req",    {63'b0, a_mem_req},    64'd0);
        chk("mid rst mem_addr",   a_mem_addr,            64'd0);
        chk("mid rst resp_valid", {63'b0, a_resp_valid}, 64'd0);
        chk("mid rst resp_data",  a_resp_data,           64'd0);
        chk("mid rst resp_fault", {63'b0, a_resp_fault}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        force_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("late rvalid resp_valid", {63'b0, a_resp_valid}, 64'd0);
            chk("late rvalid mem_req",    {63'b0, a_mem_req},    64'd0);
            chk("late rvalid req_ready",  {63'b0, a_req_ready},  64'd1);
        end
        force_rvalid = 1'b0;
        run(vecs[1], 100);
        run(vecs[0], 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/riscv_memalign.md
RISCV_MEMALIGN -- requirements
Module: riscv_memalign

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width; legal values 32 or 64; BYTES = XLEN/8.
REQ-002 SHALL have parameter MISALIGN_EN, default 1; 1 = split misaligned loads into two beats, 0 = fault on misaligned loads.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports below, clock and reset first.
REQ-004 i_riscv_memalign_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_riscv_memalign_rst  input  1  asynchronous active-high reset.
REQ-006 i_riscv_memalign_req_valid  input  1  load request valid.
REQ-007 o_riscv_memalign_req_ready  output  1  block idle, can accept a request.
REQ-008 i_riscv_memalign_sel  input  3  [1:0] size (0 byte, 1 half, 2 word, 3 dword); [2] 1 = zero-extend, 0 = sign-extend.
REQ-009 i_riscv_memalign_addr  input  XLEN  byte address of the load.
REQ-010 o_riscv_memalign_mem_req  output  1  memory read request, held until beat returns.
REQ-011 o_riscv_memalign_mem_addr  output  XLEN  BYTES-aligned read address.
REQ-012 i_riscv_memalign_mem_rvalid  input  1  read data valid for the current request.
REQ-013 i_riscv_memalign_mem_rdata  input  XLEN  read data, little-endian.
REQ-014 o_riscv_memalign_resp_valid  output  1  result valid.
REQ-015 i_riscv_memalign_resp_ready  input  1  consumer accepts result.
REQ-016 o_riscv_memalign_resp_data  output  XLEN  extended load result.
REQ-017 o_riscv_memalign_resp_fault  output  1  request was illegal; qualifies resp_valid.

Function
REQ-018 SHALL implement states IDLE, RD0, RD1, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when req_valid & req_ready, registering sel, addr, offset = addr mod BYTES.
REQ-020 Request SHALL be illegal if sel = 3'b111, or size = dword with XLEN = 32, or (MISALIGN_EN = 0 and addr not size-aligned); an illegal request SHALL go IDLE -> RESP with fault = 1, data = 0, no mem_req.
REQ-021 Legal request SHALL go IDLE -> RD0; RD0 drives mem_req = 1, mem_addr = addr with low log2(BYTES) bits cleared.
REQ-022 rvalid SHALL be sampled only while mem_req = 1; same-cycle rvalid is allowed; rvalid in IDLE/RESP SHALL be ignored.
REQ-023 On rvalid in RD0, SHALL capture beat0; if offset + (1 << size) > BYTES go RD1, else RESP.
REQ-024 RD1 SHALL drive mem_addr = beat0 address + BYTES, modulo 2^XLEN (wrap to 0 permitted); on rvalid capture beat1, go RESP.
REQ-025 Result SHALL equal the (1 << size) bytes of {beat1, beat0} starting at byte offset, sign- or zero-extended per sel[2] to XLEN; beat1 = 0 for single-beat loads.
REQ-026 RESP SHALL hold resp_valid = 1 with data/fault stable until resp_ready; then go IDLE (no request accepted in that cycle).
REQ-027 Min latency, accept in cycle N: single-beat resp_valid at N+2; two-beat N+3; fault N+1.
REQ-028 mem_req and resp_valid SHALL never be 1 in the same cycle.

Reset
REQ-029 On reset assertion, SHALL immediately enter IDLE; req_ready = 1, mem_req = 0, mem_addr = 0, resp_valid = 0, resp_data = 0, resp_fault = 0; captured beats cleared.
REQ-030 Reset mid-operation (RD0/RD1/RESP) SHALL abandon the request; late rvalid after reset SHALL be ignored.

Verification
REQ-031 XLEN=64, lb @0x1003, rdata 0x0123456789ABCDEF, zero-wait -> one read @0x1000, resp_data 0xFFFFFFFFFFFFFF89 at N+2.
REQ-032 lw @0x1006, beat0 @0x1000 = 0x0123456789ABCDEF, beat1 @0x1008 = 0x7766554433221100 -> two reads, resp_data 0x0000000011000123 at N+3.
REQ-033 MISALIGN_EN=0, lh @0x1007 -> no mem_req, resp_fault = 1, resp_data = 0 at N+1; sel=3'b111 same.
REQ-034 ld @0xFFFFFFFFFFFFFFFC -> second read mem_addr = 0x0; lwu @0x1004 rdata 0x8000000100000000 -> 0x0000000080000001.
REQ-035 resp_ready low 3 cycles -> resp_valid/data stable, req_ready = 0; rvalid delayed 4 cycles -> mem_req/mem_addr held.
REQ-036 Reset asserted in RD1 with later rvalid -> all outputs at reset values, next request served correctly.
